// File: rtl/pll_reset_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer: state encoding,
// retry counter width and the saturating increment used on every failed attempt.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    RELEASE,
    RUN,
    FAIL
  } pll_seq_state_t;

  localparam int unsigned RETRY_W           = 8;

  localparam int unsigned DEF_RST_HOLD      = 16;
  localparam int unsigned DEF_LOCK_STABLE   = 64;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 4096;
  localparam int unsigned DEF_SYS_RST_DELAY = 8;
  localparam int unsigned DEF_MAX_RETRY     = 4;

  function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Control/status bundle between the reset sequencer (master) and the PLL plus
// system-reset consumers (slave).
interface pll_reset_seq_if;
  import pll_seq_pkg::*;

  logic               pll_lock;
  logic               pll_resetb;
  logic               pll_bypass;
  logic               sys_rst_n;
  logic               locked;
  logic               lock_lost;
  logic [RETRY_W-1:0] retry_cnt;
  logic               fail;

  modport master (
    input  pll_lock,
    output pll_resetb, pll_bypass, sys_rst_n, locked, lock_lost, retry_cnt, fail
  );

  modport slave (
    output pll_lock,
    input  pll_resetb, pll_bypass, sys_rst_n, locked, lock_lost, retry_cnt, fail
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser, asynchronous active-low reset to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer and lock monitor, clocked by the board oscillator.
// Build option PLL_BYPASS_FALLBACK_EN: after exhausting retries, bypass the PLL and release sys_rst_n.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD      = DEF_RST_HOLD,
  parameter int unsigned LOCK_STABLE   = DEF_LOCK_STABLE,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned SYS_RST_DELAY = DEF_SYS_RST_DELAY,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic            clk,
  input  logic            rst_n,
  pll_reset_seq_if.master bus
);

  // The one cycle counter also times the hold and release phases, so it is
  // sized for whichever of the three limits is largest.
  localparam int unsigned CNT_W  = $clog2(max3(LOCK_TIMEOUT, RST_HOLD, SYS_RST_DELAY) + 1);
  localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   DELAY_LAST   = CNT_W'(SYS_RST_DELAY - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST    = STAB_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  pll_seq_state_t     state;
  logic [CNT_W-1:0]   cnt;
  logic [STAB_W-1:0]  stab;
  logic               lock_s;
  logic [RETRY_W-1:0] retry_inc;

  logic               resetb_q;
  logic               bypass_q;
  logic               sysrst_q;
  logic               locked_q;
  logic               lost_q;
  logic [RETRY_W-1:0] retry_q;
  logic               fail_q;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.pll_lock),
    .q     (lock_s)
  );

  assign retry_inc = retry_sat_inc(retry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PLL_RST;
      cnt      <= '0;
      stab     <= '0;
      resetb_q <= 1'b0;
      bypass_q <= 1'b0;
      sysrst_q <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      retry_q  <= '0;
      fail_q   <= 1'b0;
    end else begin
      lost_q <= 1'b0;
      cnt    <= cnt + 1'b1;

      case (state)
        PLL_RST: begin
          stab <= '0;
          if (cnt == HOLD_LAST) begin
            state    <= WAIT_LOCK;
            cnt      <= '0;
            resetb_q <= 1'b1;
          end
        end

        WAIT_LOCK: begin
          stab <= lock_s ? stab + 1'b1 : '0;
          // Stability is tested first so it wins over a coincident timeout.
          if (lock_s && (stab == STAB_LAST)) begin
            state <= RELEASE;
            cnt   <= '0;
            stab  <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_q <= retry_inc;
            cnt     <= '0;
            stab    <= '0;
            if (retry_inc >= RETRY_LIMIT) begin
              state  <= FAIL;
              fail_q <= 1'b1;
`ifdef PLL_BYPASS_FALLBACK_EN
              bypass_q <= 1'b1;
              resetb_q <= 1'b1;
`else
              bypass_q <= 1'b0;
              resetb_q <= 1'b0;
`endif
            end else begin
              state    <= PLL_RST;
              resetb_q <= 1'b0;
            end
          end
        end

        RELEASE: begin
          if (!lock_s) begin
            state    <= PLL_RST;
            cnt      <= '0;
            resetb_q <= 1'b0;
          end else if (cnt == DELAY_LAST) begin
            state    <= RUN;
            cnt      <= '0;
            sysrst_q <= 1'b1;
            locked_q <= 1'b1;
          end
        end

        RUN: begin
          cnt <= '0;
          if (!lock_s) begin
            state    <= PLL_RST;
            lost_q   <= 1'b1;
            sysrst_q <= 1'b0;
            locked_q <= 1'b0;
            resetb_q <= 1'b0;
            retry_q  <= retry_inc;
          end
        end

        FAIL: begin
          cnt <= cnt;
`ifdef PLL_BYPASS_FALLBACK_EN
          if (!sysrst_q) begin
            cnt <= cnt + 1'b1;
            if (cnt == DELAY_LAST) sysrst_q <= 1'b1;
          end
`endif
        end

        default: begin
          state    <= PLL_RST;
          cnt      <= '0;
          stab     <= '0;
          resetb_q <= 1'b0;
          sysrst_q <= 1'b0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_resetb = resetb_q;
  assign bus.pll_bypass = bypass_q;
  assign bus.sys_rst_n  = sysrst_q;
  assign bus.locked     = locked_q;
  assign bus.lock_lost  = lost_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.fail       = fail_q;

  a_lost_single: assert property (@(posedge clk) disable iff (!rst_n) lost_q |=> !lost_q);
  a_fail_unlocked: assert property (@(posedge clk) disable iff (!rst_n) !(fail_q && locked_q));
  a_locked_run: assert property (@(posedge clk) disable iff (!rst_n) locked_q == (state == RUN));

endmodule
